// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: instruction fetch stage between the Hack PC and decode.
//   Reads the instruction ROM at the PC address (req/ack), holds the word in an
//   instruction register for decode (valid/ready), pulses pc_inc once per
//   fetched instruction, and drops in-flight work on a jump (flush).
// Ports:
//   CLK, reset     clock and synchronous active-high reset
//   pc_addr        current PC value, used as the fetch address
//   pc_inc         one-cycle increment request to the PC
//   rom_req/addr   ROM read request and address (rom_addr = pc_addr)
//   rom_ack/data   ROM completion and read data (same cycle)
//   instr/valid    registered instruction and its valid flag
//   instr_ready    decode accepts instr
//   flush          jump taken; the PC is loaded this cycle
//   fetch_count    instructions accepted by decode (wraps)
//   rom_err        sticky ROM timeout flag
module hack_fetch_unit #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_addr,
    output logic             pc_inc,
    output logic             rom_req,
    output logic [WIDTH-1:0] rom_addr,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] fetch_count,
    output logic             rom_err
);

    localparam int unsigned       WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]  instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              inc_q, inc_d;
    logic [WIDTH-1:0]  fetch_count_q, fetch_count_d;
    logic              rom_err_q, rom_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks ack and ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (rom_ack) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (instr_valid_q && instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                state_d = flush ? S_FLUSH : S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs; pc_inc is masked by flush so a jump never also increments
    always_comb begin
        rom_req = (state_q == S_REQ);
        pc_inc  = inc_q & ~flush;
    end

    assign rom_addr    = pc_addr;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;
    assign rom_err     = rom_err_q;

    // Datapath next values
    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        inc_d         = 1'b0;
        fetch_count_d = fetch_count_q;
        rom_err_d     = rom_err_q;
        wait_d        = wait_q;

        case (state_q)
            S_REQ: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    wait_d        = '0;
                end else if (rom_ack) begin
                    instr_d       = rom_data;
                    instr_valid_d = 1'b1;
                    inc_d         = 1'b1;
                    wait_d        = '0;
                end else if (wait_q != WAIT_MAX) begin
                    // saturating wait count; the flag rises as it reaches the limit
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        rom_err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    wait_d        = '0;
                end else if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                    fetch_count_d = fetch_count_q + WIDTH'(1);
                end
            end
            S_FLUSH: begin
                instr_valid_d = 1'b0;
                wait_d        = '0;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            inc_q         <= 1'b0;
            fetch_count_q <= '0;
            rom_err_q     <= 1'b0;
            wait_q        <= '0;
        end else begin
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            inc_q         <= inc_d;
            fetch_count_q <= fetch_count_d;
            rom_err_q     <= rom_err_d;
            wait_q        <= wait_d;
        end
    end

endmodule
